// File: rtl/bilinear_row_scaler.sv
// Bilinear row scaler: requests two source rows per destination row from the
// 4-bank line buffer and streams RGB565 pixels interpolated between them.
module bilinear_row_scaler #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 360
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [9:0]  x_scale,
  input  logic [9:0]  y_scale,
  input  logic [10:0] dst_w,
  input  logic [10:0] dst_h,
  output logic        wr_req,
  output logic [10:0] dst_row,
  input  logic        row_ready,
  output logic        ram_rd_en,
  output logic [10:0] ram_rd_addr,
  input  logic [15:0] ram0_q,
  input  logic [15:0] ram1_q,
  input  logic [15:0] ram2_q,
  input  logic [15:0] ram3_q,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [12:0] X_MAX      = 13'(SRC_W - 1);
  localparam logic [12:0] Y_MAX      = 13'(SRC_H - 1);
  localparam logic [1:0]  Y_MAX_BANK = 2'((SRC_H - 1) % 4);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_RD0, S_RD1, S_CAP, S_MIX, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] dst_row_q, dst_row_d;
  logic [10:0] col_q, col_d;
  logic [9:0]  x_scale_q, y_scale_q;
  logic [10:0] dst_w_q, dst_h_q;
  logic [15:0] top0_q, bot0_q, top1_q, bot1_q;
  logic [15:0] pix_data_q;
  logic        frame_done_q, frame_done_d;

  logic [15:0] ram_q [4];
  assign ram_q[0] = ram0_q;
  assign ram_q[1] = ram1_q;
  assign ram_q[2] = ram2_q;
  assign ram_q[3] = ram3_q;

  // One-dimensional blend of a single colour channel, rounded to nearest.
  function automatic logic [5:0] lerp(input logic [5:0] a, input logic [5:0] b,
                                      input logic [7:0] f);
    logic [15:0] acc;
    acc = 16'(a) * (16'd256 - 16'(f)) + 16'(b) * 16'(f) + 16'd128;
    return 6'(acc >> 8);
  endfunction

  function automatic logic [15:0] mix_pixel(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] c0, input logic [15:0] c1,
                                            input logic [7:0] fx, input logic [7:0] fy);
    logic [5:0] r_t, g_t, b_t, r_b, g_b, b_b;
    r_t = lerp({1'b0, a0[15:11]}, {1'b0, a1[15:11]}, fx);
    g_t = lerp(a0[10:5], a1[10:5], fx);
    b_t = lerp({1'b0, a0[4:0]}, {1'b0, a1[4:0]}, fx);
    r_b = lerp({1'b0, c0[15:11]}, {1'b0, c1[15:11]}, fx);
    g_b = lerp(c0[10:5], c1[10:5], fx);
    b_b = lerp({1'b0, c0[4:0]}, {1'b0, c1[4:0]}, fx);
    return {5'(lerp(r_t, r_b, fy)), lerp(g_t, g_b, fy), 5'(lerp(b_t, b_b, fy))};
  endfunction

  // Source coordinates derived from the current destination row/column.
  logic [20:0] sy, sx;
  logic [12:0] y0;
  logic [7:0]  fy, fx;
  logic [1:0]  bt, bb;
  logic [10:0] x0, x1;
  logic        x_edge;

  assign sy = 21'(dst_row_q) * 21'(y_scale_q);
  assign sx = 21'(col_q) * 21'(x_scale_q);
  assign y0 = sy[20:8];
  assign fy = sy[7:0];
  assign bt = y0[1:0];
  assign bb = (y0 >= Y_MAX) ? Y_MAX_BANK : 2'(y0[1:0] + 2'd1);

  always_comb begin
    x0     = (sx[20:8] > X_MAX) ? X_MAX[10:0] : sx[18:8];
    x_edge = (x0 == X_MAX[10:0]);
    x1     = x_edge ? x0 : 11'(x0 + 11'd1);
    // A clamped column repeats the edge pixel, so its fraction must not blend.
    fx     = x_edge ? 8'd0 : sx[7:0];
  end

  logic last_col, last_row;
  assign last_col = (col_q == 11'(dst_w_q - 11'd1));
  assign last_row = (dst_row_q == 11'(dst_h_q - 11'd1));

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    dst_row_d    = dst_row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    wr_req       = 1'b0;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_REQ;
          dst_row_d = '0;
          col_d     = '0;
        end
      end
      S_REQ: begin
        wr_req  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (row_ready) begin
          state_d = S_RD0;
          col_d   = '0;
        end
      end
      S_RD0: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = x0;
        state_d     = S_RD1;
      end
      S_RD1: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = x1;
        state_d     = S_CAP;
      end
      S_CAP: state_d = S_MIX;
      S_MIX: state_d = S_OUT;
      S_OUT: begin
        if (pix_ready) begin
          if (!last_col) begin
            col_d   = 11'(col_q + 11'd1);
            state_d = S_RD0;
          end else if (!last_row) begin
            dst_row_d = 11'(dst_row_q + 11'd1);
            state_d   = S_REQ;
          end else begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      dst_row_q    <= '0;
      col_q        <= '0;
      x_scale_q    <= '0;
      y_scale_q    <= '0;
      dst_w_q      <= '0;
      dst_h_q      <= '0;
      top0_q       <= '0;
      bot0_q       <= '0;
      top1_q       <= '0;
      bot1_q       <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dst_row_q    <= dst_row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      // Frame geometry is frozen at start so mid-frame input changes cannot tear it.
      if (state_q == S_IDLE && start) begin
        x_scale_q <= x_scale;
        y_scale_q <= y_scale;
        dst_w_q   <= dst_w;
        dst_h_q   <= dst_h;
      end
      if (state_q == S_RD1) begin
        top0_q <= ram_q[bt];
        bot0_q <= ram_q[bb];
      end
      if (state_q == S_CAP) begin
        top1_q <= ram_q[bt];
        bot1_q <= ram_q[bb];
      end
      if (state_q == S_MIX) begin
        pix_data_q <= mix_pixel(top0_q, top1_q, bot0_q, bot1_q, fx, fy);
      end
    end
  end

  assign dst_row    = dst_row_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = (state_q == S_OUT);
  assign pix_last   = (state_q == S_OUT) && last_col;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bilinear_row_scaler.sv
// Directed bench for bilinear_row_scaler: a line-RAM model with 1-cycle read
// latency, a hand-driven row_ready responder and per-scenario checks.
module tb_bilinear_row_scaler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [9:0]  x_scale, y_scale;
  logic [10:0] dst_w, dst_h;
  logic        wr_req;
  logic [10:0] dst_row;
  logic        row_ready;
  logic        ram_rd_en;
  logic [10:0] ram_rd_addr;
  logic [15:0] ram0_q, ram1_q, ram2_q, ram3_q;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready, pix_last;
  logic        frame_done, busy;

  bilinear_row_scaler #(.SRC_W(640), .SRC_H(360)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .x_scale(x_scale), .y_scale(y_scale), .dst_w(dst_w), .dst_h(dst_h),
    .wr_req(wr_req), .dst_row(dst_row), .row_ready(row_ready),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram0_q(ram0_q), .ram1_q(ram1_q), .ram2_q(ram2_q), .ram3_q(ram3_q),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] bank [4][640];

  always @(posedge clk) begin
    if (ram_rd_en && ram_rd_addr < 11'd640) begin
      ram0_q <= bank[0][ram_rd_addr];
      ram1_q <= bank[1][ram_rd_addr];
      ram2_q <= bank[2][ram_rd_addr];
      ram3_q <= bank[3][ram_rd_addr];
    end
  end

  int wr_total = 0, fd_total = 0, addr_over = 0, max_addr = 0;
  always @(negedge clk) begin
    if (wr_req) wr_total <= wr_total + 1;
    if (frame_done) fd_total <= fd_total + 1;
    if (ram_rd_en && ram_rd_addr > 11'd639) addr_over <= addr_over + 1;
    if (ram_rd_en && int'(ram_rd_addr) > max_addr) max_addr <= int'(ram_rd_addr);
  end

  int checks = 0, failures = 0;
  logic [15:0] exp_data[$];
  logic [15:0] got_data[$];
  logic        got_last[$];

  function automatic bit outs_zero();
    return wr_req == 1'b0 && ram_rd_en == 1'b0 && pix_valid == 1'b0 &&
           pix_last == 1'b0 && frame_done == 1'b0 && busy == 1'b0 &&
           dst_row == 11'd0 && ram_rd_addr == 11'd0 && pix_data == 16'd0;
  endfunction

  task automatic set_cfg(input logic [9:0] xs, input logic [9:0] ys,
                         input logic [10:0] w, input logic [10:0] h);
    x_scale = xs; y_scale = ys; dst_w = w; dst_h = h;
  endtask

  task automatic load_identity_banks();
    bank[0][0] = 16'h1111; bank[0][1] = 16'h2222; bank[0][2] = 16'h3333; bank[0][3] = 16'h4444;
    bank[1][0] = 16'hAAAA; bank[1][1] = 16'hBBBB; bank[1][2] = 16'hCCCC; bank[1][3] = 16'hDDDD;
  endtask

  task automatic wait_wr_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (wr_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_row_ready();
    @(negedge clk) row_ready = 1'b1;
    @(negedge clk) row_ready = 1'b0;
  endtask

  // Accept n pixels; optionally withhold pix_ready for the pixel at stall_col.
  task automatic collect_row(input int n, input int stall_col, input int stall_cycles);
    int idx = 0;
    int budget = n * 8 + stall_cycles + 32;
    logic [15:0] hold_data;
    logic        hold_last;
    pix_ready = 1'b1;
    while (idx < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (!pix_valid && idx == stall_col) begin
        pix_ready = 1'b0;
      end else if (pix_valid) begin
        if (!pix_ready) begin
          hold_data = pix_data;
          hold_last = pix_last;
          for (int k = 0; k < stall_cycles; k++) begin
            @(negedge clk);
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== hold_data || pix_last !== hold_last ||
                ram_rd_en !== 1'b0) begin
              failures++;
              $display("FAIL backpressure_hold cyc=%0d: valid=%b data=%h last=%b rd_en=%b, want valid=1 data=%h last=%b rd_en=0",
                       k, pix_valid, pix_data, pix_last, ram_rd_en, hold_data, hold_last);
            end
          end
          pix_ready = 1'b1;
        end
        got_data.push_back(pix_data);
        got_last.push_back(pix_last);
        idx++;
      end
    end
    if (idx < n) begin
      checks++;
      failures++;
      $display("FAIL row_timeout: got %0d pixels, want %0d", idx, n);
    end
  endtask

  task automatic run_frame(input string tag, input int rows, input int cols,
                           input int stall_col, input int stall_cycles);
    int wr0, fd0;
    bit ok, seen;
    wr0 = wr_total;
    fd0 = fd_total;
    got_data.delete();
    got_last.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
    end
    for (int r = 0; r < rows; r++) begin
      wait_wr_req(ok);
      checks++;
      if (!ok || dst_row !== 11'(r)) begin
        failures++;
        $display("FAIL %s wr_req row %0d: seen=%b dst_row=%0d want seen=1 dst_row=%0d",
                 tag, r, ok, dst_row, r);
        return;
      end
      @(negedge clk);
      if (r == 0) start = 1'b1;
      @(negedge clk) start = 1'b0;
      row_ready = 1'b1;
      @(negedge clk) row_ready = 1'b0;
      collect_row(cols, stall_col, stall_cycles);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    checks++;
    if (!seen || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_done: seen=%b busy=%b want seen=1 busy=0", tag, seen, busy);
    end
    @(negedge clk);
    checks++;
    if (wr_total - wr0 != rows || fd_total - fd0 != 1) begin
      failures++;
      $display("FAIL %s pulse_counts: wr_req=%0d frame_done=%0d want %0d and 1",
               tag, wr_total - wr0, fd_total - fd0, rows);
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL %s pixel_count: got %0d want %0d", tag, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== ((i % cols) == cols - 1)) begin
        failures++;
        $display("FAIL %s pixel %0d: data=%h last=%b want data=%h last=%b", tag, i,
                 got_data[i], got_last[i], exp_data[i], (i % cols) == cols - 1);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (!outs_zero()) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b wr_req=%b valid=%b rd_en=%b data=%h want all 0",
               busy, wr_req, pix_valid, ram_rd_en, pix_data);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b wr_req=%b want 0 0", busy, wr_req);
    end
  endtask

  task automatic test_identity();
    load_identity_banks();
    set_cfg(10'h100, 10'h100, 11'd4, 11'd2);
    exp_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    run_frame("identity", 2, 4, -1, 0);
  endtask

  task automatic test_half_step();
    bank[0][0] = 16'h0000; bank[0][1] = 16'hF800; bank[0][2] = 16'h07E0;
    set_cfg(10'h080, 10'h100, 11'd4, 11'd1);
    // col3 sits halfway between R=31 and G=63: R=16, G=32.
    exp_data = '{16'h0000, 16'h8000, 16'hF800, 16'h8400};
    run_frame("half_step", 1, 4, -1, 0);
  endtask

  task automatic test_vertical();
    for (int i = 0; i < 4; i++) begin
      bank[0][i] = 16'h001F;
      bank[1][i] = 16'h0000;
      bank[2][i] = 16'hFFFF;
    end
    set_cfg(10'h100, 10'h080, 11'd4, 11'd3);
    exp_data = '{16'h001F, 16'h001F, 16'h001F, 16'h001F,
                 16'h0010, 16'h0010, 16'h0010, 16'h0010,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_frame("vertical", 3, 4, -1, 0);
  endtask

  task automatic test_right_edge();
    int over0;
    over0 = addr_over;
    for (int i = 0; i < 640; i++) bank[0][i] = 16'(i * 97 + 3);
    set_cfg(10'h200, 10'h100, 11'd640, 11'd1);
    exp_data.delete();
    for (int c = 0; c < 640; c++) exp_data.push_back(c < 320 ? bank[0][2 * c] : bank[0][639]);
    run_frame("right_edge", 1, 640, -1, 0);
    checks++;
    if (addr_over != over0 || max_addr != 639) begin
      failures++;
      $display("FAIL right_edge_addr: over=%0d max=%0d want over=0 max=639",
               addr_over - over0, max_addr);
    end
  endtask

  task automatic test_backpressure();
    load_identity_banks();
    set_cfg(10'h100, 10'h100, 11'd4, 11'd1);
    exp_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_frame("backpressure", 1, 4, 2, 10);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int activity;
    load_identity_banks();
    set_cfg(10'h100, 10'h100, 11'd4, 11'd2);
    // Abort while waiting for row_ready.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) rstn = 1'b0;
    #1;
    checks++;
    if (!outs_zero()) begin
      failures++;
      $display("FAIL reset_in_wait: busy=%b wr_req=%b dst_row=%0d want all 0", busy, wr_req, dst_row);
    end
    @(negedge clk) rstn = 1'b1;
    pulse_row_ready();
    activity = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_req || pix_valid || ram_rd_en || busy) activity++;
    end
    checks++;
    if (activity != 0) begin
      failures++;
      $display("FAIL spurious_row_ready: active cycles=%0d want 0", activity);
    end
    // Abort while a row-1 pixel is being offered.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    pulse_row_ready();
    collect_row(4, -1, 0);
    wait_wr_req(ok);
    pulse_row_ready();
    pix_ready = 1'b0;
    for (int i = 0; i < 20 && !pix_valid; i++) @(negedge clk);
    checks++;
    if (!ok || pix_valid !== 1'b1 || dst_row !== 11'd1) begin
      failures++;
      $display("FAIL reach_out_row1: wr_req=%b valid=%b dst_row=%0d want 1 1 1", ok, pix_valid, dst_row);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (!outs_zero()) begin
      failures++;
      $display("FAIL reset_in_out: valid=%b data=%h dst_row=%0d busy=%b want all 0",
               pix_valid, pix_data, dst_row, busy);
    end
    @(negedge clk) rstn = 1'b1;
    pix_ready = 1'b1;
    exp_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    run_frame("after_reset", 2, 4, -1, 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; row_ready = 1'b0; pix_ready = 1'b0;
    x_scale = '0; y_scale = '0; dst_w = '0; dst_h = '0;
    ram0_q = '0; ram1_q = '0; ram2_q = '0; ram3_q = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 640; i++) bank[b][i] = '0;
    test_reset();
    test_identity();
    test_half_step();
    test_vertical();
    test_right_edge();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
